gate_bist_ctrl: RTL and testbench
=================================

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: HOLD_CYCLES, 20, clock cycles each input vector is held (legal range 2..255).
REQ-003 Parameter: EXPECT, 4'b0111, expected gate output per vector; bit index = {gate_a,gate_b} (default = NAND).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: start  input  1  request a test run; sampled only in IDLE.
REQ-007 Port: gate_a  output  1  A input driven to the gate under test.
REQ-008 Port: gate_b  output  1  B input driven to the gate under test.
REQ-009 Port: gate_o  input  1  output returned from the gate under test.
REQ-010 Port: busy  output  1  high while a run is in progress (APPLY or REPORT).
REQ-011 Port: done  output  1  one-cycle pulse when a run completes.
REQ-012 Port: pass  output  1  result of last run, held until the next run completes.
REQ-013 Port: fail_cnt  output  3  mismatching vectors in last run (0..4).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, APPLY and REPORT.
REQ-015 IDLE with start=1 at an edge SHALL move to APPLY with vec=0, hold count=0 and the fail counter cleared.
REQ-016 In APPLY, {gate_a,gate_b} SHALL equal the 2-bit vec; in IDLE and REPORT both SHALL be 0.
REQ-017 The hold counter SHALL increment each APPLY cycle; at the edge where it equals HOLD_CYCLES-1, gate_o SHALL be compared to EXPECT[vec], with the fail counter incremented on mismatch.
REQ-018 At that same edge, vec SHALL increment and the hold counter clear if vec<3; if vec=3, the FSM SHALL enter REPORT (vec never wraps to 0 within a run).
REQ-019 REPORT SHALL last exactly one cycle, assert done=1, load fail_cnt, set pass=(fail_cnt==0), then return to IDLE.
REQ-020 done SHALL be high in the cycle following exactly 4*HOLD_CYCLES edges after the edge that sampled start.
REQ-021 start SHALL be ignored in APPLY and REPORT; held-high start SHALL begin a new run on the first IDLE edge.
REQ-022 busy SHALL be 1 in APPLY and REPORT and 0 in IDLE.
REQ-023 All outputs SHALL be registered; no combinational path from gate_o or start to any output.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, vec=0, counters=0, gate_a=gate_b=0, busy=0, done=0, pass=0, fail_cnt=0.
REQ-025 rst asserted mid-run SHALL abort the run without a done pulse; the next start SHALL run a complete sequence.

Configuration
REQ-026 With macro GATE_BIST_ERRLOG_EN defined, the block SHALL add output err_valid (1) and output err_vec (2), capturing the first mismatching vec of each run; both clear at run start and hold until the next run starts.
REQ-027 Without GATE_BIST_ERRLOG_EN, err_valid and err_vec SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-028 HOLD_CYCLES=20, ideal NAND on gate_o, start pulse -> vectors 00,01,10,11 for 20 cycles each, done 80 edges after start, pass=1, fail_cnt=0.
REQ-029 gate_o stuck at 1 -> fail_cnt=1, pass=0; with macro, err_valid=1, err_vec=2'b11.
REQ-030 gate_o stuck at 0 -> fail_cnt=3, pass=0; with macro, err_vec=2'b00.
REQ-031 rst pulsed 30 cycles into a run -> busy=0 and gate_a/b=0 immediately, no done; a following start completes with pass=1.
REQ-032 Second start pulse 10 cycles into a run -> ignored; exactly one done pulse, still 80 edges after the first start.
REQ-033 HOLD_CYCLES=2, ideal NAND -> done 8 edges after start, pass=1.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
//   Built-in self test sequencer for a single 2-input logic gate. On start it
//   walks the four input vectors {gate_a,gate_b} = 00,01,10,11, holding each
//   for HOLD_CYCLES clocks, and on the last held cycle compares the returned
//   gate output against EXPECT[vec]. After vector 11 it spends one REPORT
//   cycle pulsing done and publishing pass / fail_cnt.
//
//   Parameters
//     HOLD_CYCLES : cycles each vector is held (2..255)
//     EXPECT      : expected gate output, bit index = {gate_a,gate_b}
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     start      in   run request, only looked at in IDLE
//     gate_a/b   out  stimulus to the gate under test
//     gate_o     in   response from the gate under test
//     busy       out  high in APPLY and REPORT
//     done       out  one-cycle pulse in REPORT
//     pass       out  last run had no mismatches (held until next report)
//     fail_cnt   out  mismatching vectors in last run (0..4)
//     fsm_state  out  current FSM state (debug visibility)
//
//   Optional feature (macro GATE_BIST_ERRLOG_EN):
//     err_valid  out  a mismatch has been seen in the current/last run
//     err_vec    out  first mismatching vector of that run
//
//   Handshake: start is a level request; a run begins on any IDLE edge where
//   start=1. There is no backpressure; done is a single-cycle pulse that the
//   consumer must catch, while pass/fail_cnt stay valid until the next done.
// -----------------------------------------------------------------------------
module gate_bist_ctrl #(
  parameter int         HOLD_CYCLES = 20,
  parameter logic [3:0] EXPECT      = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_cnt,
  output logic [1:0] fsm_state
`ifdef GATE_BIST_ERRLOG_EN
  ,
  output logic       err_valid,
  output logic [1:0] err_vec
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] vec, vec_n;
  logic [7:0] hold, hold_n;
  logic [2:0] fails, fails_n;
  logic       gate_a_n, gate_b_n, busy_n, done_n, pass_n;
  logic [2:0] fail_cnt_n;
  logic       last_hold, mismatch;
`ifdef GATE_BIST_ERRLOG_EN
  logic       err_valid_n;
  logic [1:0] err_vec_n;
`endif

  assign last_hold = (hold == HOLD_LAST);
  assign mismatch  = (gate_o != EXPECT[vec]);
  assign fsm_state = state;

  always_comb begin
    state_n    = state;
    vec_n      = vec;
    hold_n     = hold;
    fails_n    = fails;
    pass_n     = pass;
    fail_cnt_n = fail_cnt;
`ifdef GATE_BIST_ERRLOG_EN
    err_valid_n = err_valid;
    err_vec_n   = err_vec;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = APPLY;
          vec_n   = 2'd0;
          hold_n  = 8'd0;
          fails_n = 3'd0;
`ifdef GATE_BIST_ERRLOG_EN
          err_valid_n = 1'b0;
          err_vec_n   = 2'd0;
`endif
        end
      end
      APPLY: begin
        hold_n = hold + 8'd1;
        if (last_hold) begin
          if (mismatch) begin
            fails_n = fails + 3'd1;
`ifdef GATE_BIST_ERRLOG_EN
            if (!err_valid) begin
              err_valid_n = 1'b1;
              err_vec_n   = vec;
            end
`endif
          end
          hold_n = 8'd0;
          if (vec == 2'd3) begin
            // vec stays at 3; it is only reloaded when the next run starts.
            state_n    = REPORT;
            fail_cnt_n = fails_n;
            pass_n     = (fails_n == 3'd0);
          end else begin
            vec_n = vec + 2'd1;
          end
        end
      end
      REPORT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    gate_a_n = (state_n == APPLY) ? vec_n[1] : 1'b0;
    gate_b_n = (state_n == APPLY) ? vec_n[0] : 1'b0;
    busy_n   = (state_n != IDLE);
    done_n   = (state_n == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= 2'd0;
      hold     <= 8'd0;
      fails    <= 3'd0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= 3'd0;
`ifdef GATE_BIST_ERRLOG_EN
      err_valid <= 1'b0;
      err_vec   <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      vec      <= vec_n;
      hold     <= hold_n;
      fails    <= fails_n;
      gate_a   <= gate_a_n;
      gate_b   <= gate_b_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      fail_cnt <= fail_cnt_n;
`ifdef GATE_BIST_ERRLOG_EN
      err_valid <= err_valid_n;
      err_vec   <= err_vec_n;
`endif
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_ctrl
//   Bench for gate_bist_ctrl. dut (HOLD_CYCLES=20) runs a table of gate
//   behaviours with results checked through an expected-result queue; dut2
//   (HOLD_CYCLES=2) covers the short-hold case and held-high start.
//   Optional feature macro: GATE_BIST_ERRLOG_EN.
// -----------------------------------------------------------------------------
module tb_gate_bist_ctrl;

  localparam int H1 = 20;
  localparam int H2 = 2;
  localparam int W  = 7;  // {pass, fail_cnt[2:0], err_valid, err_vec[1:0]}

  // gate behaviours
  localparam int M_NAND   = 0;
  localparam int M_STUCK1 = 1;
  localparam int M_STUCK0 = 2;
  localparam int M_AND    = 3;
  localparam int M_FLIP01 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- dut signals ----------------
  logic       start, gate_a, gate_b, gate_o, busy, done, pass;
  logic [2:0] fail_cnt;
  logic [1:0] st;
  logic       start2, gate_a2, gate_b2, gate_o2, busy2, done2, pass2;
  logic [2:0] fail_cnt2;
  logic [1:0] st2;
  logic [2:0] act_err, act_err2;
  int         gmode;
`ifdef GATE_BIST_ERRLOG_EN
  logic       err_valid, err_valid2;
  logic [1:0] err_vec, err_vec2;
  assign act_err  = {err_valid, err_vec};
  assign act_err2 = {err_valid2, err_vec2};
`else
  assign act_err  = 3'b000;
  assign act_err2 = 3'b000;
`endif

  function automatic logic gate_model(input int m, input logic a, input logic b);
    case (m)
      M_STUCK1: return 1'b1;
      M_STUCK0: return 1'b0;
      M_AND:    return a & b;
      M_FLIP01: return ~(a & b) ^ (~a & b);
      default:  return ~(a & b);
    endcase
  endfunction

  assign gate_o  = gate_model(gmode, gate_a, gate_b);
  assign gate_o2 = gate_model(M_NAND, gate_a2, gate_b2);

  gate_bist_ctrl #(.HOLD_CYCLES(H1), .EXPECT(4'b0111)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_a(gate_a), .gate_b(gate_b),
    .gate_o(gate_o), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .fsm_state(st)
`ifdef GATE_BIST_ERRLOG_EN
    , .err_valid(err_valid), .err_vec(err_vec)
`endif
  );

  gate_bist_ctrl #(.HOLD_CYCLES(H2), .EXPECT(4'b0111)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_a(gate_a2), .gate_b(gate_b2),
    .gate_o(gate_o2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_cnt(fail_cnt2), .fsm_state(st2)
`ifdef GATE_BIST_ERRLOG_EN
    , .err_valid(err_valid2), .err_vec(err_vec2)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic p, input logic [2:0] fc,
                                             input logic ev, input logic [1:0] evec);
`ifdef GATE_BIST_ERRLOG_EN
    return {p, fc, ev, evec};
`else
    return {p, fc, 3'b000} | {6'b0, ev & evec[0] & 1'b0};
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", {25'b0, pass, fail_cnt, act_err}, {25'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    string      name;
    int         mode;
    logic       restart;
    logic       exp_pass;
    logic [2:0] exp_fc;
    logic       exp_ev;
    logic [1:0] exp_evec;
  } row_t;

  row_t rows[7];
  logic       prev_pass;
  logic [2:0] prev_fc;

  task automatic run_row(input row_t r);
    int k;
    int bad;
    int d0;
    logic [1:0] exp_v;
    @(negedge clk);
    gmode = r.mode;
    start = 1'b1;
    exp_q.push_back(exp_word(r.exp_pass, r.exp_fc, r.exp_ev, r.exp_evec));
    d0 = done_seen;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    bad = 0;
    check({r.name, "_held_result"}, {28'b0, pass, fail_cnt}, {28'b0, prev_pass, prev_fc});
`ifdef GATE_BIST_ERRLOG_EN
    check({r.name, "_err_clear"}, {29'b0, act_err}, 32'd0);
`endif
    while (!done && k < 4 * H1 + 10) begin
      exp_v = 2'(k / H1);
      if ({gate_a, gate_b} !== exp_v || busy !== 1'b1) bad++;
      if (r.restart && k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check({r.name, "_done_latency"}, k, 4 * H1);
    check({r.name, "_vector_bad_cycles"}, bad, 0);
    check({r.name, "_report_outputs"}, {29'b0, gate_a, gate_b, busy}, 32'b001);
    @(negedge clk);
    check({r.name, "_back_idle"}, {28'b0, busy, done, st}, 32'd0);
    repeat (3) @(negedge clk);
    check({r.name, "_done_pulses"}, done_seen - d0, 1);
    prev_pass = r.exp_pass;
    prev_fc   = r.exp_fc;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int d0;
    int t1;
    int t2;
    rows[0] = '{"nand",    M_NAND,   1'b0, 1'b1, 3'd0, 1'b0, 2'd0};
    rows[1] = '{"stuck1",  M_STUCK1, 1'b0, 1'b0, 3'd1, 1'b1, 2'd3};
    rows[2] = '{"stuck0",  M_STUCK0, 1'b0, 1'b0, 3'd3, 1'b1, 2'd0};
    rows[3] = '{"and",     M_AND,    1'b0, 1'b0, 3'd4, 1'b1, 2'd0};
    rows[4] = '{"flip01",  M_FLIP01, 1'b0, 1'b0, 3'd1, 1'b1, 2'd1};
    rows[5] = '{"restart", M_NAND,   1'b1, 1'b1, 3'd0, 1'b0, 2'd0};
    rows[6] = '{"stuck1b", M_STUCK1, 1'b0, 1'b0, 3'd1, 1'b1, 2'd3};

    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    gmode = M_NAND;
    prev_pass = 1'b0;
    prev_fc = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {gate_a, gate_b, busy, done, pass, fail_cnt, st, act_err},
          32'd0);
    check("reset_state2", {gate_a2, gate_b2, busy2, done2, pass2, fail_cnt2, st2, act_err2},
          32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_row(rows[i]);

    // mid-run reset aborts without a done pulse
    @(negedge clk);
    gmode = M_NAND;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_reset_vec", {30'b0, gate_a, gate_b}, 32'b01);
    d0 = done_seen;
    rst = 1'b1;
    #1;
    check("reset_abort", {27'b0, busy, gate_a, gate_b, done, pass}, 32'd0);
    check("reset_abort_cnt", {29'b0, fail_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4 * H1 + 5) @(negedge clk);
    check("no_done_after_abort", done_seen - d0, 0);
    prev_pass = 1'b0;
    prev_fc = 3'd0;
    run_row(rows[0]);

    // short hold, start held high: back-to-back runs
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && k < 40) begin
      if (done2) begin
        if (t1 < 0) t1 = k;
        else t2 = k;
        if (t1 == k) check("short_pass", {28'b0, pass2, fail_cnt2}, 32'b1000);
      end
      @(negedge clk);
      k++;
    end
    start2 = 1'b0;
    check("short_done_latency", t1, 4 * H2);
    check("held_start_rerun_gap", t2 - t1, 4 * H2 + 2);
    repeat (2) @(negedge clk);
    check("short_idle", {30'b0, busy2, done2}, 32'd0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
